// File: rtl/cpu_6502_bus_pkg.sv
// Shared definitions for the 6502 bus front end: phase-machine encoding,
// default timing parameters and parameter sanity rules.
package cpu_6502_bus_pkg;

  localparam int PHI_DIV_DEF    = 8;
  localparam int RES_CYCLES_DEF = 8;
  localparam int PHI_DIV_MIN    = 4;
  localparam int RES_CYCLES_MIN = 1;

  localparam logic [1:0] ST_PH1      = 2'd0;
  localparam logic [1:0] ST_PH2_WAIT = 2'd1;
  localparam logic [1:0] ST_PH2_REQ  = 2'd2;
  localparam logic [1:0] ST_PH2_DONE = 2'd3;

  function automatic bit params_ok(input int phi_div, input int res_cycles);
    return (phi_div >= PHI_DIV_MIN) && ((phi_div % 2) == 0) &&
           (res_cycles >= RES_CYCLES_MIN);
  endfunction

endpackage

// File: rtl/cpu_6502_phi_gen.sv
// Phi clock generator: half-period phase counter, phi2 stretching and the
// power-on core reset sequence counted in whole phi cycles.
module cpu_6502_phi_gen
  import cpu_6502_bus_pkg::*;
#(
  parameter int PHI_DIV    = PHI_DIV_DEF,
  parameter int RES_CYCLES = RES_CYCLES_DEF,
  localparam int CNT_W     = $clog2(PHI_DIV)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             stretch,
  output logic             phi,
  output logic [CNT_W-1:0] cnt,
  output logic             cpu_res,
  output logic             phi_fall
);

  localparam int RES_W = $clog2(RES_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHI_DIV - 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RES_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phi_q, phi_d;
  logic [RES_W-1:0] res_cnt_q, res_cnt_d;
  logic             cpu_res_q, cpu_res_d;
  logic             phi_fall_s;

  // Phase counting; in phi2 the count saturates while the bus side stretches.
  always_comb begin
    cnt_d      = cnt_q;
    phi_d      = phi_q;
    res_cnt_d  = res_cnt_q;
    cpu_res_d  = cpu_res_q;
    phi_fall_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      if (!phi_q) begin
        phi_d = 1'b1;
        cnt_d = '0;
      end else if (!stretch) begin
        phi_d      = 1'b0;
        cnt_d      = '0;
        phi_fall_s = 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (phi_fall_s && !cpu_res_q) begin
      if (res_cnt_q == RES_LAST) begin
        cpu_res_d = 1'b1;
      end else begin
        res_cnt_d = res_cnt_q + RES_W'(1);
      end
    end else begin
      res_cnt_d = res_cnt_q;
    end
  end

  // Phase and reset-sequence registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q     <= '0;
      phi_q     <= 1'b0;
      res_cnt_q <= '0;
      cpu_res_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      phi_q     <= phi_d;
      res_cnt_q <= res_cnt_d;
      cpu_res_q <= cpu_res_d;
    end
  end

  assign phi      = phi_q;
  assign cnt      = cnt_q;
  assign cpu_res  = cpu_res_q;
  assign phi_fall = phi_fall_s;

endmodule

// File: rtl/cpu_6502_bus_if.sv
// Bus front end for the netlist 6502: one req/ack memory transaction per phi
// cycle, with phi2 held high until memory has answered.
module cpu_6502_bus_if
  import cpu_6502_bus_pkg::*;
#(
  parameter int PHI_DIV    = PHI_DIV_DEF,
  parameter int RES_CYCLES = RES_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        res,
  output logic        phi,
  output logic        cpu_res,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dbo,
  output logic [7:0]  cpu_dbi,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] cyc_cnt
);

  localparam int CNT_W = $clog2(PHI_DIV);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(PHI_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHI_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_REQ  = CNT_W'(PHI_DIV / 2 - 1);

  generate
    if (!params_ok(PHI_DIV, RES_CYCLES)) begin : g_param_check
      $error("cpu_6502_bus_if: PHI_DIV must be even and >= 4, RES_CYCLES >= 1");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]       cpu_dbi_q, cpu_dbi_d;
  logic [31:0]      cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] cnt_s;
  logic             cpu_res_s;
  logic             phi_fall_s;
  logic             ack_s;
  logic             stretch_s;

  cpu_6502_phi_gen #(
    .PHI_DIV    (PHI_DIV),
    .RES_CYCLES (RES_CYCLES)
  ) u_phi_gen (
    .clk      (clk),
    .res      (res),
    .stretch  (stretch_s),
    .phi      (phi),
    .cnt      (cnt_s),
    .cpu_res  (cpu_res_s),
    .phi_fall (phi_fall_s)
  );

  // Acks only count against a raised request; phi2 may end in the ack clk itself.
  always_comb begin
    ack_s     = mem_req_q & mem_ack;
    stretch_s = !((state_q == ST_PH2_DONE) || ((state_q == ST_PH2_REQ) && ack_s));
  end

  // Transaction sequencing and capture registers.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_dbi_d   = cpu_dbi_q;
    cyc_cnt_d   = cyc_cnt_q;
    case (state_q)
      ST_PH1: begin
        if (cnt_s == CNT_CAP) begin
          mem_addr_d = cpu_ab;
          mem_we_d   = ~cpu_rw;
        end else begin
          mem_addr_d = mem_addr_q;
        end
        if (cnt_s == CNT_LAST) begin
          state_d = ST_PH2_WAIT;
        end else begin
          state_d = ST_PH1;
        end
      end
      ST_PH2_WAIT: begin
        if (cnt_s == CNT_REQ) begin
          mem_wdata_d = cpu_dbo;
          if (cpu_res_s) begin
            mem_req_d = 1'b1;
            state_d   = ST_PH2_REQ;
          end else begin
            state_d = ST_PH2_DONE;
          end
        end else begin
          state_d = ST_PH2_WAIT;
        end
      end
      ST_PH2_REQ: begin
        if (ack_s) begin
          mem_req_d = 1'b0;
          cpu_dbi_d = mem_we_q ? cpu_dbi_q : mem_rdata;
          state_d   = phi_fall_s ? ST_PH1 : ST_PH2_DONE;
        end else begin
          state_d = ST_PH2_REQ;
        end
      end
      ST_PH2_DONE: begin
        if (phi_fall_s) begin
          state_d = ST_PH1;
        end else begin
          state_d = ST_PH2_DONE;
        end
      end
      default: begin
        state_d   = ST_PH1;
        mem_req_d = 1'b0;
      end
    endcase
    if (phi_fall_s && cpu_res_s) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end
  end

  // Registered bus outputs; res aborts any pending request immediately.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= ST_PH1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      cpu_dbi_q   <= 8'h00;
      cyc_cnt_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_dbi_q   <= cpu_dbi_d;
      cyc_cnt_q   <= cyc_cnt_d;
    end
  end

  assign cpu_res   = cpu_res_s;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_dbi   = cpu_dbi_q;
  assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_cpu_6502_bus_if.sv
// Randomized bench for cpu_6502_bus_if: a per-phi-cycle timeline model queues
// the expected output of every clk and a negedge process compares against it.
module tb_cpu_6502_bus_if;

  localparam int PHI_DIV    = 8;
  localparam int RES_CYCLES = 8;
  localparam int P2         = PHI_DIV / 2;

  logic        clk = 1'b0;
  logic        res;
  logic        phi, cpu_res;
  logic [15:0] cpu_ab;
  logic        cpu_rw;
  logic [7:0]  cpu_dbo, cpu_dbi;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] cyc_cnt;

  cpu_6502_bus_if #(.PHI_DIV(PHI_DIV), .RES_CYCLES(RES_CYCLES)) dut (
    .clk(clk), .res(res), .phi(phi), .cpu_res(cpu_res),
    .cpu_ab(cpu_ab), .cpu_rw(cpu_rw), .cpu_dbo(cpu_dbo), .cpu_dbi(cpu_dbi),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          phi;
    bit          req;
    bit          cres;
    logic [31:0] cyc;
    logic [7:0]  dbi;
    bit          chk_bus;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          rst;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hi_run   = 0;
  bit          m_rel;
  int          m_rescnt;
  logic [31:0] m_cyc;
  logic [7:0]  m_dbi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (phi === 1'b1) hi_run++;
    else hi_run = 0;
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      check("phi", 32'(phi), 32'(cur.phi));
      check("mem_req", 32'(mem_req), 32'(cur.req));
      check("cpu_res", 32'(cpu_res), 32'(cur.cres));
      check("cyc_cnt", cyc_cnt, cur.cyc);
      check("cpu_dbi", 32'(cpu_dbi), 32'(cur.dbi));
      if (cur.chk_bus) begin
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        check("mem_we", 32'(mem_we), 32'(cur.we));
        if (cur.we) check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      end
      if (cur.rst) begin
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
      end
    end
  end

  function automatic exp_t base_exp();
    exp_t e;
    e.phi = 1'b0; e.req = 1'b0; e.cres = m_rel; e.cyc = m_cyc; e.dbi = m_dbi;
    e.chk_bus = 1'b0; e.we = 1'b0; e.addr = 16'h0000; e.wdata = 8'h00; e.rst = 1'b0;
    return e;
  endfunction

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    res = 1'b0;
    m_rel = 1'b0; m_rescnt = 0; m_cyc = 32'd0; m_dbi = 8'h00;
    for (int i = 0; i < n; i++) begin
      e = base_exp();
      e.rst = 1'b1;
      step(e);
    end
    res = 1'b1;
  endtask

  // One full phi cycle: PHI_DIV clk low, then high until the planned ack (d clk after req).
  task automatic phi_cycle(input logic [15:0] ab, input bit rw, input logic [7:0] dbo,
                           input logic [7:0] rdata, input int d, input bit stray,
                           input bit wrap, input int abort_h);
    exp_t e;
    bit   rel;
    int   hlen;
    rel = m_rel;
    cpu_ab = ab; cpu_rw = rw; cpu_dbo = dbo; mem_rdata = rdata;
    for (int i = 0; i < PHI_DIV; i++) begin
      mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      if (wrap && i == 0) begin
        force dut.cyc_cnt_q = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
      end
      e = base_exp();
      step(e);
      if (wrap && i == 0) release dut.cyc_cnt_q;
    end
    hlen = (rel && (P2 + d + 1 > PHI_DIV)) ? (P2 + d + 1) : PHI_DIV;
    for (int h = 0; h < hlen; h++) begin
      if (h == abort_h) return;
      e = base_exp();
      e.phi = 1'b1;
      e.req = rel && (h >= P2) && (h <= P2 + d);
      if (e.req) begin
        mem_ack = (h == P2 + d);
        e.chk_bus = 1'b1; e.addr = ab; e.we = !rw; e.wdata = dbo;
      end else begin
        mem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      step(e);
      if (e.req && (h == P2 + d) && rw) m_dbi = rdata;
    end
    mem_ack = 1'b0;
    if (rel) begin
      m_cyc = m_cyc + 32'd1;
    end else begin
      m_rescnt++;
      if (m_rescnt == RES_CYCLES) m_rel = 1'b1;
    end
  endtask

  initial begin
    int d;
    res = 1'b0; cpu_ab = 16'h0000; cpu_rw = 1'b1; cpu_dbo = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    m_rel = 1'b0; m_rescnt = 0; m_cyc = 32'd0; m_dbi = 8'h00;
    @(posedge clk);
    #1;
    do_reset(3);

    // Reset sequence: no requests until cpu_res rises on the RES_CYCLES-th fall.
    for (int k = 0; k < RES_CYCLES; k++)
      phi_cycle(16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 3, 1'b0, 1'b0, -1);
    check("seq_cpu_res", 32'(cpu_res), 32'd1);
    check("seq_cyc_cnt", cyc_cnt, 32'd0);
    check("seq_phi_high", 32'(hi_run), 32'd8);

    phi_cycle(16'hFFFC, 1'b1, 8'h00, 8'h34, 0, 1'b0, 1'b0, -1);
    check("rd_dbi", 32'(cpu_dbi), 32'h34);
    check("rd_phi_high", 32'(hi_run), 32'd8);

    phi_cycle(16'h0200, 1'b0, 8'hA5, 8'h5A, 20, 1'b0, 1'b0, -1);
    check("wr_phi_high", 32'(hi_run), 32'd25);
    check("wr_dbi_hold", 32'(cpu_dbi), 32'h34);

    phi_cycle(16'h1234, 1'b1, 8'h00, 8'hC3, 2, 1'b1, 1'b0, -1);
    check("stray_cyc_cnt", cyc_cnt, 32'd3);
    check("stray_dbi", 32'(cpu_dbi), 32'hC3);

    for (int k = 0; k < 30; k++) begin
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 5));
      phi_cycle(16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), d,
                1'($urandom), 1'b0, -1);
    end

    phi_cycle(16'hABCD, 1'b1, 8'h00, 8'h77, 0, 1'b0, 1'b1, -1);
    check("wrap_cyc_cnt", cyc_cnt, 32'd0);
    check("wrap_phi_high", 32'(hi_run), 32'd8);

    // Reset in the middle of a stretched request, with a stale ack held across it.
    phi_cycle(16'h0300, 1'b0, 8'h11, 8'h22, 30, 1'b0, 1'b0, P2 + 5);
    mem_ack = 1'b1;
    do_reset(3);
    for (int k = 0; k < RES_CYCLES + 2; k++)
      phi_cycle(16'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1, k < 2, 1'b0, -1);
    check("abort_cpu_res", 32'(cpu_res), 32'd1);
    check("abort_cyc_cnt", cyc_cnt, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
